// File: rtl/aplic_src_conditioner.sv
// APLIC interrupt-source front end: N-stage synchroniser, optional per-source glitch filter,
// registered level plus rise/fall pulses. The filter is built only when APLIC_SRC_GLITCH_FILTER_EN is defined.
module aplic_src_conditioner #(
   parameter int NR_SRC      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_CYC  = 4
) (
   input  logic              i_clk,
   input  logic              ni_rst,
   input  logic [NR_SRC-1:0] i_irq_sources,
   input  logic [NR_SRC-1:0] i_filter_en,
   output logic [NR_SRC-1:0] o_irq_level,
   output logic [NR_SRC-1:0] o_irq_rise,
   output logic [NR_SRC-1:0] o_irq_fall
);

   if (NR_SRC < 1) begin : g_bad_nr_src
      $error("aplic_src_conditioner: NR_SRC must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("aplic_src_conditioner: SYNC_STAGES must be >= 2");
   end
   if (FILTER_CYC < 1) begin : g_bad_filter
      $error("aplic_src_conditioner: FILTER_CYC must be >= 1");
   end

   logic [NR_SRC-1:0] sync_r [SYNC_STAGES];
   logic [NR_SRC-1:0] sync_s;
   logic [NR_SRC-1:0] level_next_s;

   // Synchroniser chain; the last stage is the metastability-safe view of each line.
   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= {NR_SRC{1'b0}};
         end
      end else begin
         sync_r[0] <= i_irq_sources;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
         end
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef APLIC_SRC_GLITCH_FILTER_EN
   localparam int CNT_W = $clog2(FILTER_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYC - 1);

   logic [CNT_W-1:0] cnt_r      [NR_SRC];
   logic [CNT_W-1:0] cnt_next_s [NR_SRC];

   // Per-source debounce: a change is taken only after FILTER_CYC consecutive differing cycles.
   always_comb begin
      for (int i = 0; i < NR_SRC; i++) begin
         level_next_s[i] = o_irq_level[i];
         cnt_next_s[i]   = {CNT_W{1'b0}};
         if (!i_filter_en[i]) begin
            level_next_s[i] = sync_s[i];
         end else if (sync_s[i] == o_irq_level[i]) begin
            cnt_next_s[i] = {CNT_W{1'b0}};
         end else if (cnt_r[i] == CNT_LAST) begin
            level_next_s[i] = sync_s[i];
         end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // Filter counter state; a reset discards any partial count.
   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         for (int i = 0; i < NR_SRC; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NR_SRC; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end
`else
   logic [NR_SRC-1:0] unused_filter_en_s;
   assign unused_filter_en_s = i_filter_en;

   // Without the filter every source follows its synchronised line directly.
   always_comb begin
      level_next_s = sync_s;
   end
`endif

   // Level and edge pulses are registered together so a pulse marks the cycle the level changes.
   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         o_irq_level <= {NR_SRC{1'b0}};
         o_irq_rise  <= {NR_SRC{1'b0}};
         o_irq_fall  <= {NR_SRC{1'b0}};
      end else begin
         o_irq_level <= level_next_s;
         o_irq_rise  <= level_next_s & ~o_irq_level;
         o_irq_fall  <= ~level_next_s & o_irq_level;
      end
   end

endmodule
